rc5_stream_ctrl: RTL and testbench
==================================

// Module: rc5_stream_ctrl
// PURPOSE
//  Byte-stream front-end for the rc5 block core: packs input bytes into 32-bit blocks and drives rc5 start/d_in.
//  Captures rc5 d_out on done and streams result bytes out with valid/ready backpressure.
//  Sits directly upstream/downstream of rc5; key loading (load_key/key_ready) stays at rc5, this block only observes key_ready.
// PARAMETERS
//  CNT_W     16  width of blk_count completed-block counter
// PORTS
//  clk            in   1   system clock
//  rst            in   1   asynchronous, active-low reset
//  s_valid        in   1   input byte valid
//  s_ready        out  1   input byte accepted when s_valid&s_ready
//  s_data         in   8   input byte
//  s_last         in   1   marks final byte of message
//  mode_dec       in   1   0=encrypt,1=decrypt; sampled on first byte of each message
//  iv             in   32  chaining IV; sampled on first byte of message (used only with RC5_CBC_EN)
//  m_valid        out  1   output byte valid
//  m_ready        in   1   downstream accepts output byte
//  m_data         out  8   output byte
//  m_last         out  1   final output byte of message
//  core_key_ready in   1   from rc5 key_ready
//  core_start_enc out  1   to rc5 start_encrypt, one-cycle pulse
//  core_start_dec out  1   to rc5 start_decrypt, one-cycle pulse
//  core_d_in      out  32  to rc5 d_in, held stable from start pulse until done
//  core_d_out     in   32  from rc5 d_out
//  core_done      in   1   from rc5 done
//  busy           out  1   high whenever state != IDLE
//  blk_count      out  CNT_W  blocks completed since reset, wraps to 0
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; s_ready,m_valid,m_last,core_start_*,busy=0; m_data,core_d_in,blk_count,chain=0.
//  Packing little-endian: byte k of block -> bits[8k+7:8k]; output unpacked same order.
//  FSM: IDLE -> FILL on first accepted byte (latch mode_dec, iv->chain); FILL -> ISSUE after 4th byte or s_last;
//   ISSUE (1 cycle: start pulse) -> WAIT; WAIT -> DRAIN on first core_done=1 at least 1 cycle after pulse (latch d_out);
//   DRAIN emits 4 bytes; after 4th handshake -> FILL if message continues, else IDLE.
//  s_ready=1 only in IDLE/FILL and only while core_key_ready=1; key_ready low in IDLE/FILL stalls input, no data loss.
//  s_last on byte index <3: remaining bytes zero-padded; output is always whole blocks (4 bytes each).
//  m_last=1 on 4th byte of the block containing s_last; message flag cleared on that handshake.
//  m_valid/m_data/m_last held stable while m_valid&~m_ready; no input accepted during ISSUE/WAIT/DRAIN.
//  Latency: 4th input byte accept -> start pulse next cycle; done capture -> m_valid next cycle.
//  blk_count increments on each core_done capture; wraps 2^CNT_W-1 -> 0.
//  core_start_enc = ISSUE & ~mode; core_start_dec = ISSUE & mode; never both high.
//  Reset mid-WAIT/DRAIN: partial block discarded; rc5 must also be reset (shared rst).
// CONFIGURATION
//  RC5_CBC_EN defined: CBC chaining. Enc: core_d_in=P^chain, chain<=C(captured). Dec: core_d_in=C,
//   output=D^chain, chain<=C (input block). chain<=iv at message start.
//  RC5_CBC_EN undefined: ECB; core_d_in=P or C, output=core_d_out; iv ignored, no chain register.
// TESTING
//  1 ECB: key 0xdeadbeef x4, encrypt bytes 78 56 34 12 (s_last on 4th) -> core_d_in=0x12345678, 4 out bytes=model, m_last on 4th.
//  2 Round trip: encrypt 8-byte msg 00..07, feed output back with mode_dec=1 -> 00..07 returned, blk_count=4.
//  3 Partial: 5 bytes 11 22 33 44 55 s_last -> 2nd block core_d_in=0x00000055, 8 output bytes.
//  4 Backpressure: m_ready=0 for 10 cycles in DRAIN -> m_data/m_valid stable, s_ready=0, no start pulses.
//  5 key_ready=0 with s_valid=1 in IDLE -> s_ready=0, busy=0; raise key_ready -> byte accepted next edge.
//  6 CBC (RC5_CBC_EN): iv=0, 1 block == ECB result; iv=0xFFFFFFFF, 2 blocks -> matches model, decrypt restores plaintext.

Source files
------------

// File: rtl/rc5_stream_ctrl.sv
// rc5_stream_ctrl: byte-stream front-end for the rc5 block core.
// Packs input bytes little-endian into 32-bit blocks, drives the rc5 start
// pulses and d_in, captures d_out on done and streams it back out as bytes.
// Optional feature macro: RC5_CBC_EN selects CBC chaining. When it is
// undefined the block runs in ECB mode, ignores iv and has no chain register.

module rc5_stream_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [7:0]       s_data,
    input  logic             s_last,
    input  logic             mode_dec,
    input  logic [31:0]      iv,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [7:0]       m_data,
    output logic             m_last,
    input  logic             core_key_ready,
    output logic             core_start_enc,
    output logic             core_start_dec,
    output logic [31:0]      core_d_in,
    input  logic [31:0]      core_d_out,
    input  logic             core_done,
    output logic             busy,
    output logic [CNT_W-1:0] blk_count
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        accept;
    logic        blk_final;
    logic [1:0]  in_idx;
    logic [31:0] in_buf;
    logic [31:0] blk_word;
    logic [31:0] din_word;
    logic [31:0] core_result;
    logic        mode;
    logic        msg_end;
    logic [31:0] out_buf;
    logic [1:0]  out_idx;
    logic [1:0]  out_idx_nxt;

    assign out_idx_nxt = out_idx + 2'd1;

    // Current block with the byte being offered dropped into its lane; lanes
    // above it are still zero, which gives the padding for short blocks.
    always_comb begin
        blk_word = in_buf;
        blk_word[{in_idx, 3'b000} +: 8] = s_data;
    end

`ifdef RC5_CBC_EN
    logic [31:0] chain;
    logic        eff_mode;
    logic [31:0] eff_chain;

    // On the first byte of a message mode and chain are being loaded on the
    // same edge, so use the incoming values for a single-byte message.
    always_comb begin
        eff_mode    = (state == IDLE) ? mode_dec : mode;
        eff_chain   = (state == IDLE) ? iv : chain;
        din_word    = eff_mode ? blk_word : (blk_word ^ eff_chain);
        core_result = mode ? (core_d_out ^ chain) : core_d_out;
    end
`else
    logic unused_iv;

    // ECB: the core sees the block as-is and its output goes straight out.
    always_comb begin
        din_word    = blk_word;
        core_result = core_d_out;
        unused_iv   = ^iv;
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus the handshake and core-control outputs.
    always_comb begin
        state_nxt      = state;
        s_ready        = 1'b0;
        accept         = 1'b0;
        blk_final      = 1'b0;
        core_start_enc = 1'b0;
        core_start_dec = 1'b0;
        busy           = (state != IDLE);

        s_ready   = rst && core_key_ready && ((state == IDLE) || (state == FILL));
        accept    = s_valid && s_ready;
        blk_final = accept && (s_last || (in_idx == 2'd3));

        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = blk_final ? ISSUE : FILL;
                end
            end
            FILL: begin
                if (blk_final) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                core_start_enc = ~mode;
                core_start_dec = mode;
                state_nxt      = WAIT;
            end
            WAIT: begin
                if (core_done) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (m_valid && m_ready && (out_idx == 2'd3)) begin
                    state_nxt = msg_end ? IDLE : FILL;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: byte packing, block hand-off to the core, result capture
    // and byte-wise unpacking towards the output stream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_idx    <= 2'd0;
            in_buf    <= 32'd0;
            mode      <= 1'b0;
            msg_end   <= 1'b0;
            core_d_in <= 32'd0;
            out_buf   <= 32'd0;
            out_idx   <= 2'd0;
            m_valid   <= 1'b0;
            m_data    <= 8'd0;
            m_last    <= 1'b0;
            blk_count <= '0;
`ifdef RC5_CBC_EN
            chain     <= 32'd0;
`endif
        end else begin
            if (accept) begin
                if (state == IDLE) begin
                    mode <= mode_dec;
`ifdef RC5_CBC_EN
                    chain <= iv;
`endif
                end
                if (blk_final) begin
                    in_buf    <= 32'd0;
                    in_idx    <= 2'd0;
                    msg_end   <= s_last;
                    core_d_in <= din_word;
                end else begin
                    in_buf <= blk_word;
                    in_idx <= in_idx + 2'd1;
                end
            end

            if ((state == WAIT) && core_done) begin
                out_buf   <= core_result;
                out_idx   <= 2'd0;
                m_valid   <= 1'b1;
                m_data    <= core_result[7:0];
                m_last    <= 1'b0;
                blk_count <= blk_count + 1'b1;
`ifdef RC5_CBC_EN
                chain <= mode ? core_d_in : core_d_out;
`endif
            end

            if ((state == DRAIN) && m_valid && m_ready) begin
                if (out_idx == 2'd3) begin
                    m_valid <= 1'b0;
                    m_last  <= 1'b0;
                    msg_end <= 1'b0;
                end else begin
                    out_idx <= out_idx_nxt;
                    m_data  <= out_buf[{out_idx_nxt, 3'b000} +: 8];
                    m_last  <= msg_end && (out_idx == 2'd2);
                end
            end
        end
    end

endmodule

// File: tb/tb_rc5_stream_ctrl.sv
// tb_rc5_stream_ctrl: directed bench for rc5_stream_ctrl. An RC5-16/12/16
// core stand-in answers the start pulses; expected bytes come from the same
// cipher applied to the hand-built blocks (chained when RC5_CBC_EN is set).

module tb_rc5_stream_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        s_last;
    logic        mode_dec;
    logic [31:0] iv;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        m_last;
    logic        core_key_ready;
    logic        core_start_enc;
    logic        core_start_dec;
    logic [31:0] core_d_in;
    logic [31:0] core_d_out = 32'd0;
    logic        core_done = 1'b0;
    logic        busy;
    logic [15:0] blk_count;

    int          checks = 0;
    int          errors = 0;

    logic [15:0] S [0:25];
    logic [8:0]  out_q[$];
    logic [31:0] din_q[$];
    logic [8:0]  exp_q[$];
    logic [31:0] exp_din_q[$];
    logic [7:0]  msg [0:15];
    int          start_cnt = 0;
    logic        dual_seen = 1'b0;

    rc5_stream_ctrl #(.CNT_W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .s_last         (s_last),
        .mode_dec       (mode_dec),
        .iv             (iv),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .m_last         (m_last),
        .core_key_ready (core_key_ready),
        .core_start_enc (core_start_enc),
        .core_start_dec (core_start_dec),
        .core_d_in      (core_d_in),
        .core_d_out     (core_d_out),
        .core_done      (core_done),
        .busy           (busy),
        .blk_count      (blk_count)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rotl16(input logic [15:0] x, input logic [15:0] s);
        logic [31:0] t;
        t = {x, x} << s[3:0];
        return t[31:16];
    endfunction

    function automatic logic [15:0] rotr16(input logic [15:0] x, input logic [15:0] s);
        logic [31:0] t;
        t = {x, x} >> s[3:0];
        return t[15:0];
    endfunction

    task automatic rc5Setup();
        logic [15:0]  L [0:7];
        logic [127:0] key;
        logic [15:0]  a;
        logic [15:0]  b;
        int           i;
        int           j;
        key = {4{32'hdeadbeef}};
        for (int k = 0; k < 8; k++) L[k] = key[16*k +: 16];
        S[0] = 16'hB7E1;
        for (int k = 1; k < 26; k++) S[k] = S[k-1] + 16'h9E37;
        a = 16'd0;
        b = 16'd0;
        i = 0;
        j = 0;
        for (int k = 0; k < 78; k++) begin
            a    = rotl16(S[i] + a + b, 16'd3);
            S[i] = a;
            b    = rotl16(L[j] + a + b, a + b);
            L[j] = b;
            i    = (i + 1) % 26;
            j    = (j + 1) % 8;
        end
    endtask

    function automatic logic [31:0] rc5Enc(input logic [31:0] d);
        logic [15:0] a;
        logic [15:0] b;
        a = d[15:0] + S[0];
        b = d[31:16] + S[1];
        for (int r = 1; r <= 12; r++) begin
            a = rotl16(a ^ b, b) + S[2*r];
            b = rotl16(b ^ a, a) + S[2*r+1];
        end
        return {b, a};
    endfunction

    function automatic logic [31:0] rc5Dec(input logic [31:0] d);
        logic [15:0] a;
        logic [15:0] b;
        a = d[15:0];
        b = d[31:16];
        for (int r = 12; r >= 1; r--) begin
            b = rotr16(b - S[2*r+1], a) ^ a;
            a = rotr16(a - S[2*r], b) ^ b;
        end
        b = b - S[1];
        a = a - S[0];
        return {b, a};
    endfunction

    // Core stand-in: latch d_in on a start pulse, answer with done three cycles later.
    always begin : core_model
        int          pend;
        logic [31:0] pend_res;
        pend = 0;
        pend_res = 32'd0;
        forever begin
            @(negedge clk);
            #1;
            core_done = 1'b0;
            if (pend > 0) begin
                pend = pend - 1;
                if (pend == 0) begin
                    core_done  = 1'b1;
                    core_d_out = pend_res;
                end
            end
            if (core_start_enc && core_start_dec) dual_seen = 1'b1;
            if (core_start_enc || core_start_dec) begin
                din_q.push_back(core_d_in);
                pend_res  = core_start_dec ? rc5Dec(core_d_in) : rc5Enc(core_d_in);
                pend      = 3;
                start_cnt = start_cnt + 1;
            end
        end
    end

    // Output collector: record every byte that completes a handshake at the next edge.
    always begin
        @(negedge clk);
        #1;
        if (m_valid && m_ready) out_q.push_back({m_last, m_data});
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic last, input logic dec,
                                 input logic [31:0] ivv);
        int g;
        g = 0;
        @(negedge clk);
        s_valid  = 1'b1;
        s_data   = d;
        s_last   = last;
        mode_dec = dec;
        iv       = ivv;
        forever begin
            #1;
            if (s_ready) begin
                @(posedge clk);
                #1;
                s_valid = 1'b0;
                break;
            end
            @(negedge clk);
            g = g + 1;
            if (g > 500) begin
                checkOutput("tx_timeout", 32'd1, 32'd0);
                s_valid = 1'b0;
                break;
            end
        end
    endtask

    task automatic sendMsg(input int n, input logic dec, input logic [31:0] ivv);
        for (int i = 0; i < n; i++) applyStimulus(msg[i], (i == n - 1), dec, ivv);
    endtask

    task automatic waitOut(input int n);
        int g;
        g = 0;
        while ((out_q.size() < n) && (g < 500)) begin
            @(negedge clk);
            g = g + 1;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic buildExpected(input int n, input logic dec, input logic [31:0] ivv);
        logic [31:0] w;
        logic [31:0] din;
        logic [31:0] r;
        logic [31:0] chain;
        int          nblk;
        exp_q.delete();
        exp_din_q.delete();
        chain = ivv;
        nblk  = (n + 3) / 4;
        for (int b = 0; b < nblk; b++) begin
            w = 32'd0;
            for (int k = 0; k < 4; k++) if (4*b + k < n) w[8*k +: 8] = msg[4*b + k];
`ifdef RC5_CBC_EN
            if (!dec) begin
                din   = w ^ chain;
                r     = rc5Enc(din);
                chain = r;
            end else begin
                din   = w;
                r     = rc5Dec(w) ^ chain;
                chain = w;
            end
`else
            din = w;
            r   = dec ? rc5Dec(w) : rc5Enc(w);
`endif
            exp_din_q.push_back(din);
            for (int k = 0; k < 4; k++)
                exp_q.push_back({(b == nblk - 1) && (k == 3), r[8*k +: 8]});
        end
    endtask

    task automatic compareOutputs(input string tag);
        logic [8:0]  o;
        logic [31:0] d;
        checkOutput({tag, "_nbytes"}, 32'(out_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            o = (i < out_q.size()) ? out_q[i] : 9'bx;
            checkOutput({tag, "_byte"}, 32'(o), 32'(exp_q[i]));
        end
        for (int i = 0; i < exp_din_q.size(); i++) begin
            d = (i < din_q.size()) ? din_q[i] : 32'bx;
            checkOutput({tag, "_din"}, d, exp_din_q[i]);
        end
    endtask

    task automatic clearQueues();
        out_q.delete();
        din_q.delete();
    endtask

    task automatic doReset();
        @(negedge clk);
        rst     = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0]  held_data;
        logic        stable;
        int          starts_before;
        logic [31:0] ref_word;

        rc5Setup();
        rst            = 1'b0;
        s_valid        = 1'b0;
        s_data         = 8'd0;
        s_last         = 1'b0;
        mode_dec       = 1'b0;
        iv             = 32'd0;
        m_ready        = 1'b1;
        core_key_ready = 1'b1;

        // Reset state
        #1;
        checkOutput("rst_s_ready", 32'(s_ready), 32'd0);
        checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
        checkOutput("rst_m_last", 32'(m_last), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_blk_count", 32'(blk_count), 32'd0);
        checkOutput("rst_core_d_in", core_d_in, 32'd0);
        checkOutput("rst_m_data", 32'(m_data), 32'd0);
        checkOutput("rst_starts", 32'({core_start_enc, core_start_dec}), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Test 1: one ECB block, bytes 78 56 34 12
        $display("[TB] test 1: single block encrypt");
        clearQueues();
        msg[0] = 8'h78; msg[1] = 8'h56; msg[2] = 8'h34; msg[3] = 8'h12;
        sendMsg(4, 1'b0, 32'd0);
        waitOut(4);
        checkOutput("t1_din_packed", (din_q.size() > 0) ? din_q[0] : 32'bx, 32'h12345678);
        checkOutput("t1_m_last_pattern",
                    32'((out_q.size() == 4) ? {out_q[3][8], out_q[2][8], out_q[1][8], out_q[0][8]} : 4'bx),
                    32'h8);
        buildExpected(4, 1'b0, 32'd0);
        compareOutputs("t1");
        checkOutput("t1_blk_count", 32'(blk_count), 32'd1);

        // Test 2: round trip of 00..07
        $display("[TB] test 2: round trip");
        doReset();
        clearQueues();
        for (int i = 0; i < 8; i++) msg[i] = 8'(i);
        sendMsg(8, 1'b0, 32'd0);
        waitOut(8);
        buildExpected(8, 1'b0, 32'd0);
        compareOutputs("t2_enc");
        for (int i = 0; i < 8; i++) msg[i] = (i < out_q.size()) ? out_q[i][7:0] : 8'd0;
        clearQueues();
        sendMsg(8, 1'b1, 32'd0);
        waitOut(8);
        for (int i = 0; i < 8; i++)
            checkOutput("t2_plain", 32'((i < out_q.size()) ? out_q[i][7:0] : 8'bx), 32'(i));
        checkOutput("t2_blk_count", 32'(blk_count), 32'd4);

        // Test 3: 5-byte message, second block zero padded
        $display("[TB] test 3: partial block");
        clearQueues();
        msg[0] = 8'h11; msg[1] = 8'h22; msg[2] = 8'h33; msg[3] = 8'h44; msg[4] = 8'h55;
        sendMsg(5, 1'b0, 32'd0);
        waitOut(8);
`ifndef RC5_CBC_EN
        checkOutput("t3_din_pad", (din_q.size() > 1) ? din_q[1] : 32'bx, 32'h00000055);
`endif
        checkOutput("t3_din_first", (din_q.size() > 0) ? din_q[0] : 32'bx, 32'h44332211);
        buildExpected(5, 1'b0, 32'd0);
        compareOutputs("t3");

        // Test 4: output backpressure for 10 cycles
        $display("[TB] test 4: backpressure");
        clearQueues();
        @(negedge clk);
        m_ready = 1'b0;
        msg[0] = 8'hA1; msg[1] = 8'hB2; msg[2] = 8'hC3; msg[3] = 8'hD4;
        sendMsg(4, 1'b0, 32'd0);
        for (int g = 0; (g < 100) && !m_valid; g++) @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("t4_m_valid_up", 32'(m_valid), 32'd1);
        held_data     = m_data;
        starts_before = start_cnt;
        stable        = 1'b1;
        s_valid       = 1'b1;
        s_data        = 8'hEE;
        s_last        = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            if (!m_valid || (m_data !== held_data) || s_ready || m_last) stable = 1'b0;
        end
        checkOutput("t4_hold_stable", 32'(stable), 32'd1);
        checkOutput("t4_no_starts", 32'(start_cnt), 32'(starts_before));
        s_valid = 1'b0;
        @(negedge clk);
        m_ready = 1'b1;
        waitOut(4);
        buildExpected(4, 1'b0, 32'd0);
        compareOutputs("t4");

        // Test 5: key not ready stalls the first byte in IDLE
        $display("[TB] test 5: key_ready stall");
        clearQueues();
        @(negedge clk);
        core_key_ready = 1'b0;
        s_valid        = 1'b1;
        s_data         = 8'hAB;
        s_last         = 1'b1;
        mode_dec       = 1'b0;
        iv             = 32'd0;
        #1;
        checkOutput("t5_s_ready_low", 32'(s_ready), 32'd0);
        checkOutput("t5_busy_low", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("t5_still_idle", 32'(busy), 32'd0);
        @(negedge clk);
        core_key_ready = 1'b1;
        #1;
        checkOutput("t5_s_ready_high", 32'(s_ready), 32'd1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        checkOutput("t5_accepted", 32'(busy), 32'd1);
        waitOut(4);
        msg[0] = 8'hAB;
        buildExpected(1, 1'b0, 32'd0);
        compareOutputs("t5");

`ifdef RC5_CBC_EN
        // Test 6: CBC chaining
        $display("[TB] test 6: cbc");
        clearQueues();
        msg[0] = 8'h78; msg[1] = 8'h56; msg[2] = 8'h34; msg[3] = 8'h12;
        sendMsg(4, 1'b0, 32'd0);
        waitOut(4);
        ref_word = rc5Enc(32'h12345678);
        for (int k = 0; k < 4; k++)
            checkOutput("t6_iv0_eq_ecb", 32'((k < out_q.size()) ? out_q[k][7:0] : 8'bx),
                        32'(ref_word[8*k +: 8]));
        clearQueues();
        for (int i = 0; i < 8; i++) msg[i] = 8'(8'h40 + i);
        sendMsg(8, 1'b0, 32'hFFFFFFFF);
        waitOut(8);
        buildExpected(8, 1'b0, 32'hFFFFFFFF);
        compareOutputs("t6_enc");
        for (int i = 0; i < 8; i++) msg[i] = (i < out_q.size()) ? out_q[i][7:0] : 8'd0;
        clearQueues();
        sendMsg(8, 1'b1, 32'hFFFFFFFF);
        waitOut(8);
        for (int i = 0; i < 8; i++)
            checkOutput("t6_plain", 32'((i < out_q.size()) ? out_q[i][7:0] : 8'bx), 32'(8'h40 + i));
`endif

        checkOutput("dual_start", 32'(dual_seen), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
